// File: rtl/nv_ram_rws_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : nv_ram_rws_param                                                   |
// | Brief  : 1R1W lane-masked RAM, self-clearing after reset, optional out reg  |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module nv_ram_rws_param #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int DW      = 256,
    parameter int MW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [MW-1:0] wmask,
    input  logic [DW-1:0] di,
    output logic          init_done,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int            c_LANE_W = DW / MW;
    localparam logic [AW-1:0] c_LAST   = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_DEPTH  = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clear_ptr;
    logic [AW-1:0] w_clear_ptr_nxt;
    logic          r_init_done;

    logic [DW-1:0] mem [DEPTH];

    logic          w_wa_ok;
    logic          w_ra_ok;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [DW-1:0] w_wr_old;
    logic [DW-1:0] w_wr_word;
    logic [DW-1:0] w_rd_word;

    logic          r_rd_vld;
    logic [DW-1:0] r_rd_data;

    wire           w_unused_pwr = ^pwrbus_ram_pd;

    // Clearing FSM: walks every entry once, then opens the user ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_clear_ptr <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_ptr <= w_clear_ptr_nxt;
            r_init_done <= (w_state_nxt == ST_READY);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear_ptr_nxt = r_clear_ptr;
        case (r_state)
            ST_INIT: begin
                w_clear_ptr_nxt = r_clear_ptr + 1'b1;
                if (r_clear_ptr == c_LAST) begin
                    w_state_nxt     = ST_READY;
                    w_clear_ptr_nxt = '0;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt     = ST_INIT;
                w_clear_ptr_nxt = '0;
            end
        endcase
    end

    assign init_done = r_init_done;

    assign w_wa_ok  = ({1'b0, wa} < c_DEPTH);
    assign w_ra_ok  = ({1'b0, ra} < c_DEPTH);
    assign w_wr_en  = !rst && (r_state == ST_READY) && we && w_wa_ok;
    assign w_rd_en  = !rst && (r_state == ST_READY) && re;
    assign w_wr_old = w_wa_ok ? mem[wa] : '0;

    generate
        for (genvar g = 0; g < MW; g++) begin : g_lane
            assign w_wr_word[g*c_LANE_W +: c_LANE_W] =
                wmask[g] ? di[g*c_LANE_W +: c_LANE_W] : w_wr_old[g*c_LANE_W +: c_LANE_W];
        end
    endgenerate

    // Write-first: a same-address write in this cycle is visible to the read.
    always_comb begin
        w_rd_word = '0;
        if (w_ra_ok) begin
            if (w_wr_en && (ra == wa)) begin
                w_rd_word = w_wr_word;
            end else begin
                w_rd_word = mem[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_INIT)) begin
            mem[r_clear_ptr] <= '0;
        end else if (w_wr_en) begin
            mem[wa] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          r_out_vld;
            logic [DW-1:0] r_out_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_vld  <= 1'b0;
                    r_out_data <= '0;
                end else begin
                    r_out_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign dout     = r_out_data;
            assign dout_vld = r_out_vld;
        end else begin : g_no_out_reg
            assign dout     = r_rd_data;
            assign dout_vld = r_rd_vld;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rws_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_nv_ram_rws_param                                                |
// | Brief  : randomized bench, two RAM variants against a behavioural model     |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module tb_nv_ram_rws_param;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int MW = 32;
    localparam int LW = DW / MW;
    localparam int D0 = 256;
    localparam int D1 = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra = '0;
    logic          re = 1'b0;
    logic [AW-1:0] wa = '0;
    logic          we = 1'b0;
    logic [MW-1:0] wmask = '0;
    logic [DW-1:0] di = '0;
    logic [31:0]   pwr = '0;

    logic [DW-1:0] dout0, dout1;
    logic          vld0, vld1, done0, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nv_ram_rws_param #(.DEPTH(D0), .AW(AW), .DW(DW), .MW(MW), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .init_done(done0), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rws_param #(.DEPTH(D1), .AW(AW), .DW(DW), .MW(MW), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .init_done(done1), .pwrbus_ram_pd(pwr)
    );

    // Behavioural model: per variant, a word array plus the value each output should show.
    logic [DW-1:0] m_mem [2][256];
    int            m_cnt [2];
    bit            m_rdy [2];
    bit            e_vld [2];
    logic [DW-1:0] e_dat [2];
    bit            p_vld;
    logic [DW-1:0] p_dat;
    bit            started = 1'b0;

    function automatic int dep(int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nd, logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < MW; i++) begin
            if (m[i]) r[i*LW +: LW] = nd[i*LW +: LW];
        end
        return r;
    endfunction

    // Evaluated at the clock edge with the inputs that edge samples.
    task automatic model_step();
        logic [DW-1:0] old_w, new_w, rd;
        bit            nxt_p_vld;
        logic [DW-1:0] nxt_p_dat;
        nxt_p_vld = 1'b0;
        nxt_p_dat = p_dat;
        if (rst) begin
            started = 1'b1;
            p_vld = 1'b0;
            p_dat = '0;
            for (int k = 0; k < 2; k++) begin
                m_rdy[k] = 1'b0; m_cnt[k] = 0; e_vld[k] = 1'b0; e_dat[k] = '0;
            end
            return;
        end
        // Variant 1 output follows its internal read stage one cycle later.
        e_vld[1] = p_vld;
        if (p_vld) e_dat[1] = p_dat;
        e_vld[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!m_rdy[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == dep(k)) begin
                    m_rdy[k] = 1'b1;
                    for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
                end
            end else begin
                old_w = (int'(wa) < dep(k)) ? m_mem[k][wa] : '0;
                new_w = merge(old_w, di, wmask);
                if (re) begin
                    if (int'(ra) >= dep(k)) rd = '0;
                    else if (we && ra == wa) rd = new_w;
                    else rd = m_mem[k][ra];
                    if (k == 0) begin
                        e_vld[0] = 1'b1; e_dat[0] = rd;
                    end else begin
                        nxt_p_vld = 1'b1; nxt_p_dat = rd;
                    end
                end
                if (we && int'(wa) < dep(k)) m_mem[k][wa] = new_w;
            end
        end
        p_vld = nxt_p_vld;
        p_dat = nxt_p_dat;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("vld0",  DW'(vld0),  DW'(e_vld[0]));
            chk("dout0", dout0,      e_dat[0]);
            chk("done0", DW'(done0), DW'(m_rdy[0]));
            chk("vld1",  DW'(vld1),  DW'(e_vld[1]));
            chk("dout1", dout1,      e_dat[1]);
            chk("done1", DW'(done1), DW'(m_rdy[1]));
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_init(input bit pulse_re, output int n0, output int n1);
        int n;
        n = 0; n0 = -1; n1 = -1;
        while ((n0 < 0 || n1 < 0) && n < 600) begin
            re = pulse_re && (n % 3 == 0);
            ra = AW'(n);
            tick();
            n++;
            if (done0 && n0 < 0) n0 = n;
            if (done1 && n1 < 0) n1 = n;
        end
        re = 1'b0;
    endtask

    initial begin
        int n0, n1, c;
        logic [DW-1:0] x, y, v, exp_w;
        pwr = $urandom;
        tick();
        do_reset();
        chk("rst_dout0", dout0, '0);
        chk("rst_vld0", DW'(vld0), '0);
        chk("rst_done0", DW'(done0), '0);
        wait_init(1'b1, n0, n1);
        chk("init_cycles0", DW'(n0), DW'(256));
        chk("init_cycles1", DW'(n1), DW'(200));

        // Full-mask write then read of entry 5.
        we = 1'b1; wa = 8'd5; wmask = '1; di = {32{8'hA5}};
        tick();
        we = 1'b0; re = 1'b1; ra = 8'd5;
        tick();
        re = 1'b0;
        chk("rd5_dout0", dout0, {32{8'hA5}});
        chk("rd5_vld0", DW'(vld0), DW'(1));
        tick();
        chk("rd5_dout1", dout1, {32{8'hA5}});
        chk("rd5_vld1", DW'(vld1), DW'(1));

        // Same-address single-lane write with concurrent read.
        we = 1'b1; wa = 8'd7; wmask = '1; di = {32{8'h11}};
        tick();
        re = 1'b1; ra = 8'd7; wmask = 32'h0000_0001; di = {32{8'hFF}};
        tick();
        re = 1'b0; we = 1'b0;
        exp_w = {{31{8'h11}}, 8'hFF};
        chk("wf_dout0", dout0, exp_w);

        // Held dout must not follow a later write to the same address.
        x = rnd_word(); y = rnd_word();
        we = 1'b1; wa = 8'd3; wmask = '1; di = x;
        tick();
        we = 1'b0; re = 1'b1; ra = 8'd3;
        tick();
        re = 1'b0; we = 1'b1; di = y;
        tick();
        we = 1'b0;
        tick();
        chk("hold_dout0", dout0, x);
        chk("hold_dout1", dout1, x);

        // Address beyond the smaller variant's depth.
        v = rnd_word();
        we = 1'b1; wa = 8'd250; wmask = '1; di = v;
        tick();
        we = 1'b0; re = 1'b1; ra = 8'd250;
        tick();
        re = 1'b0;
        chk("oor_dout0", dout0, v);
        tick();
        chk("oor_dout1", dout1, '0);
        chk("oor_vld1", DW'(vld1), DW'(1));

        // Back-to-back reads with writes one address ahead.
        c = 0;
        for (int i = 0; i < 256; i++) begin
            re = 1'b1; ra = AW'(i);
            we = 1'b1; wa = AW'(i + 1); wmask = $urandom; di = rnd_word();
            tick();
            if (vld0) c++;
        end
        re = 1'b0; we = 1'b0;
        chk("b2b_pulses", DW'(c), DW'(256));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                wait_init(1'b0, n0, n1);
            end
            re = $urandom_range(0, 1); ra = AW'($urandom);
            we = $urandom_range(0, 1); wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom);
            wmask = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
            di = rnd_word();
            tick();
        end
        re = 1'b0; we = 1'b0;

        // Reset part-way through clearing, then every entry must read zero.
        we = 1'b1; wa = 8'd5; wmask = '1; di = {32{8'hA5}};
        tick();
        we = 1'b0;
        do_reset();
        repeat (100) tick();
        do_reset();
        wait_init(1'b0, n0, n1);
        chk("reinit_cycles0", DW'(n0), DW'(256));
        for (int i = 0; i < 256; i++) begin
            re = 1'b1; ra = AW'(i);
            tick();
            if (i == 5) chk("reinit_rd5", dout0, '0);
        end
        re = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nv_ram_rws_param.md
NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of words.
REQ-002 SHALL have parameter AW, default 8: address width; DEPTH <= 2^AW.
REQ-003 SHALL have parameter DW, default 256: data width.
REQ-004 SHALL have parameter MW, default 32: write-mask lanes; DW divisible by MW, lane = DW/MW bits.
REQ-005 SHALL have parameter OUT_REG, default 0: 1 adds one output pipeline stage.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port ra  input  AW  read address.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port dout  output  DW  read data.
REQ-011 SHALL have port dout_vld  output  1  one-cycle pulse marking new dout.
REQ-012 SHALL have port wa  input  AW  write address.
REQ-013 SHALL have port we  input  1  write enable.
REQ-014 SHALL have port wmask  input  MW  per-lane write enable, bit i covers di[i*DW/MW +: DW/MW].
REQ-015 SHALL have port di  input  DW  write data.
REQ-016 SHALL have port init_done  output  1  high once memory clear completes.
REQ-017 SHALL have port pwrbus_ram_pd  input  32  power-control bus, no functional effect.

Function
REQ-018 SHALL implement an FSM with states INIT and READY; rst forces INIT with clear pointer 0.
REQ-019 SHALL, in INIT, write all-zero to entry clear_ptr each cycle, increment clear_ptr, and enter READY after entry DEPTH-1 is written (exactly DEPTH cycles after rst deasserts).
REQ-020 SHALL drive init_done high in READY only, registered, low during and after rst.
REQ-021 SHALL ignore re and we in INIT; no dout_vld pulse, no user writes.
REQ-022 SHALL, in READY with we=1, write lanes with wmask[i]=1 at wa; lanes with wmask[i]=0 unchanged; we with wmask=0 is a no-op.
REQ-023 SHALL, in READY with re=1, return M[ra] on dout with latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), with dout_vld high in that same cycle.
REQ-024 SHALL hold dout stable between accepted reads; later writes to the read address SHALL NOT alter held dout.
REQ-025 SHALL, for re and we in the same cycle with ra==wa, return the merged post-write word (write-first): masked lanes from di, others from old M.
REQ-026 SHALL, for re and we in the same cycle with ra!=wa, perform both independently.
REQ-027 SHALL treat addresses >= DEPTH as no-op writes; reads return all-zero with dout_vld still pulsed.
REQ-028 SHALL sustain one read and one write per cycle back-to-back with no bubbles.

Reset
REQ-029 SHALL reset dout to 0, dout_vld to 0, init_done to 0, and all pipeline valids to 0.
REQ-030 SHALL, on rst asserted mid-INIT or mid-READY, drop in-flight reads (no dout_vld) and restart clearing from entry 0.
REQ-031 SHALL guarantee every entry reads 0 after init_done rises, regardless of prior contents.

Verification
REQ-032 SHALL cover: rst 1 cycle, DEPTH=256 -> init_done rises exactly 256 cycles after rst falls; re pulsed during INIT -> no dout_vld.
REQ-033 SHALL cover: write wa=5 di=all-0xA5 wmask=all-1, then re ra=5 -> dout=all-0xA5, dout_vld one cycle later (OUT_REG=0) or two (OUT_REG=1).
REQ-034 SHALL cover: entry 7 = all-0x11, write wa=7 di=all-0xFF wmask=0x0000_0001 with re ra=7 same cycle -> dout lane0=0xFF..., lanes 1-31 = 0x11...
REQ-035 SHALL cover: read ra=3 returns X, then write wa=3 new value with re=0 -> dout remains X until next read.
REQ-036 SHALL cover: back-to-back reads ra=0..255 each cycle with concurrent writes to ra+1 -> 256 consecutive dout_vld pulses, data matching a reference model.
REQ-037 SHALL cover: rst asserted at clear_ptr=100 after user writes -> INIT restarts at 0, all entries read 0 after init_done.
